// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave controller and its shift registers.
package spi_pkg;

  localparam int ADDR_SIZE_DEF = 8;
  localparam int WORD_W        = ADDR_SIZE_DEF + 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with bit counter; serial in at the LSB, serial out from the MSB.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic [W-1:0] data,
  output logic         serial_out,
  output logic         last,
  output logic         done
);

  localparam int CNT_W = $clog2(W + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift_en && !done) begin
      data  <= {data[W-2:0], serial_in};
      count <= count + 1'b1;
    end
  end

  assign serial_out = data[W-1];
  // last marks the shift that completes the word, so callers can strobe on that same edge
  assign last       = (count == CNT_W'(W - 1));
  assign done       = (count == CNT_W'(W));

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end/sequencer for the 256x8 SPI RAM.
// Optional read-data timeout enabled by defining SPI_READ_TIMEOUT_EN.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE      = ADDR_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef SPI_READ_TIMEOUT_EN
  output logic                 rd_timeout,
`endif
  output logic [2:0]           state,
  output logic                 rd_addr_flag
);

  // Handshakes: rx_valid is a single-cycle strobe, rx_data is meaningful only while it is high;
  // tx_valid is sampled only in READ_DATA after the command strobe, once per frame, no backpressure.
  state_t               state_q;
  logic                 in_frame, rx_shift, rx_last, rx_done, rx_msb;
  logic                 tx_load, tx_shift, tx_last, tx_done, tx_msb, tx_loaded;
  logic [ADDR_SIZE-1:0] tx_bits;
  logic                 timed_out, timeout_hit;

  assign in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
  assign rx_shift = !SS_n && in_frame && !rx_done;
  assign tx_load  = !SS_n && (state_q == READ_DATA) && rx_done && !tx_loaded && !timed_out && tx_valid;
  assign tx_shift = !SS_n && (state_q == READ_DATA) && tx_loaded && !tx_done;
  assign MISO     = (state_q == READ_DATA) && tx_loaded && !tx_done && tx_msb;
  assign state    = state_q;

  spi_shift_reg #(.W(ADDR_SIZE + 2)) u_rx_sr (
    .clk(clk), .rst_n(rst_n), .clear(SS_n), .load(1'b0), .load_data('0),
    .shift_en(rx_shift), .serial_in(MOSI), .data(rx_data), .serial_out(rx_msb),
    .last(rx_last), .done(rx_done)
  );

  spi_shift_reg #(.W(ADDR_SIZE)) u_tx_sr (
    .clk(clk), .rst_n(rst_n), .clear(SS_n), .load(tx_load), .load_data(tx_data),
    .shift_en(tx_shift), .serial_in(1'b0), .data(tx_bits), .serial_out(tx_msb),
    .last(tx_last), .done(tx_done)
  );

`ifdef SPI_READ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            waiting;

  assign waiting     = !SS_n && (state_q == READ_DATA) && rx_done && !tx_loaded && !timed_out && !tx_valid;
  assign timeout_hit = waiting && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      timed_out  <= 1'b0;
      rd_timeout <= 1'b0;
    end else begin
      rd_timeout <= timeout_hit;
      if (SS_n) begin
        wait_cnt  <= '0;
        timed_out <= 1'b0;
      end else if (timeout_hit) begin
        timed_out <= 1'b1;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign timed_out      = 1'b0;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_valid     <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_loaded    <= 1'b0;
    end else begin
      rx_valid <= rx_shift && rx_last;
      if ((tx_shift && tx_last) || timeout_hit) rd_addr_flag <= 1'b0;
      if (SS_n) begin
        state_q   <= IDLE;
        tx_loaded <= 1'b0;
      end else begin
        case (state_q)
          IDLE:      state_q <= CHK_CMD;
          CHK_CMD:   state_q <= MOSI ? (rd_addr_flag ? READ_DATA : READ_ADD) : WRITE;
          READ_ADD:  if (rx_shift && rx_last) rd_addr_flag <= 1'b1;
          READ_DATA: if (tx_load) tx_loaded <= 1'b1;
          default:   ;
        endcase
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{rx_msb, tx_bits};

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed self-checking bench for spi_slave_ctrl (timeout test runs when SPI_READ_TIMEOUT_EN is defined).
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, tx_valid, MISO, rx_valid, rd_addr_flag;
  logic [7:0] tx_data;
  logic [9:0] rx_data;
  logic [2:0] state;
`ifdef SPI_READ_TIMEOUT_EN
  logic       rd_timeout;
`endif

  int checks = 0;
  int passes = 0;

  spi_slave_ctrl #(.ADDR_SIZE(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
`ifdef SPI_READ_TIMEOUT_EN
    .rd_timeout(rd_timeout),
`endif
    .state(state), .rd_addr_flag(rd_addr_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SS_n low for one cycle (IDLE->CHK_CMD), then the selector bit.
  task automatic start_frame(input logic sel);
    SS_n = 1'b0;
    MOSI = $urandom_range(0, 1);
    step();
    MOSI = sel;
    step();
  endtask

  task automatic send_word(input logic [9:0] w, input int nbits, output logic [9:0] vpat,
                           output logic [9:0] cap);
    vpat = '0;
    cap  = '0;
    for (int i = 9; i > 9 - nbits; i--) begin
      MOSI = w[i];
      step();
      vpat[i] = rx_valid;
      if (rx_valid) cap = rx_data;
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    step();
    checks++; if (rx_data !== 10'h000) $display("FAIL reset rx_data: got %h want 000", rx_data); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset rx_valid: got %b want 0", rx_valid); else passes++;
    checks++; if (MISO !== 1'b0) $display("FAIL reset MISO: got %b want 0", MISO); else passes++;
    checks++; if (state !== IDLE) $display("FAIL reset state: got %0d want 0", state); else passes++;
    checks++; if (rd_addr_flag !== 1'b0) $display("FAIL reset rd_addr_flag: got %b want 0", rd_addr_flag); else passes++;
`ifdef SPI_READ_TIMEOUT_EN
    checks++; if (rd_timeout !== 1'b0) $display("FAIL reset rd_timeout: got %b want 0", rd_timeout); else passes++;
`endif
    rst_n = 1'b1;
    step();
    checks++; if (state !== IDLE) $display("FAIL post_reset state: got %0d want 0", state); else passes++;
  endtask

  task automatic test_write_addr();
    logic [9:0] vpat, cap;
    start_frame(1'b0);
    checks++; if (state !== WRITE) $display("FAIL wr_addr state: got %0d want 2", state); else passes++;
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_word(10'h005, 10, vpat, cap);
    tx_valid = 1'b0;
    checks++; if (vpat !== 10'b00_0000_0001) $display("FAIL wr_addr rx_valid timing: got %b want 0000000001", vpat); else passes++;
    checks++; if (cap !== 10'h005) $display("FAIL wr_addr rx_data: got %h want 005", cap); else passes++;
    checks++; if (MISO !== 1'b0) $display("FAIL wr_addr MISO: got %b want 0", MISO); else passes++;
    MOSI = 1'b1;
    step();
    checks++; if (rx_valid !== 1'b0) $display("FAIL wr_addr extra strobe: got %b want 0", rx_valid); else passes++;
    end_frame();
    checks++; if (state !== IDLE) $display("FAIL wr_addr end state: got %0d want 0", state); else passes++;
    checks++; if (rx_data !== 10'h000) $display("FAIL wr_addr cleared rx_data: got %h want 000", rx_data); else passes++;
  endtask

  task automatic test_write_data();
    logic [9:0] vpat, cap;
    logic [2:0] extra;
    start_frame(1'b0);
    send_word(10'h1AA, 10, vpat, cap);
    checks++; if (vpat !== 10'b00_0000_0001) $display("FAIL wr_data rx_valid timing: got %b want 0000000001", vpat); else passes++;
    checks++; if (cap !== 10'h1AA) $display("FAIL wr_data rx_data: got %h want 1aa", cap); else passes++;
    extra = '0;
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      step();
      extra[i] = rx_valid;
    end
    checks++; if (extra !== 3'b000) $display("FAIL wr_data extra bits strobe: got %b want 000", extra); else passes++;
    checks++; if (rx_data !== 10'h1AA) $display("FAIL wr_data extra bits rx_data: got %h want 1aa", rx_data); else passes++;
    end_frame();
  endtask

  task automatic test_read_pair();
    logic [9:0] vpat, cap;
    logic [7:0] bits;
    int wait_cycles;
`ifdef SPI_READ_TIMEOUT_EN
    wait_cycles = 2;
`else
    wait_cycles = 6;
`endif
    start_frame(1'b1);
    checks++; if (state !== READ_ADD) $display("FAIL rd_addr state: got %0d want 3", state); else passes++;
    send_word(10'h205, 10, vpat, cap);
    checks++; if (vpat !== 10'b00_0000_0001) $display("FAIL rd_addr rx_valid timing: got %b want 0000000001", vpat); else passes++;
    checks++; if (cap !== 10'h205) $display("FAIL rd_addr rx_data: got %h want 205", cap); else passes++;
    checks++; if (rd_addr_flag !== 1'b1) $display("FAIL rd_addr flag set: got %b want 1", rd_addr_flag); else passes++;
    end_frame();
    checks++; if (rd_addr_flag !== 1'b1) $display("FAIL rd_addr flag kept: got %b want 1", rd_addr_flag); else passes++;
    start_frame(1'b1);
    checks++; if (state !== READ_DATA) $display("FAIL rd_data state: got %0d want 4", state); else passes++;
    send_word(10'h3C3, 10, vpat, cap);
    checks++; if (cap[9:8] !== CMD_RD_DATA) $display("FAIL rd_data cmd: got %b want 11", cap[9:8]); else passes++;
    checks++; if (vpat !== 10'b00_0000_0001) $display("FAIL rd_data rx_valid timing: got %b want 0000000001", vpat); else passes++;
    for (int i = 0; i < wait_cycles; i++) step();
    checks++; if (MISO !== 1'b0) $display("FAIL rd_data idle MISO: got %b want 0", MISO); else passes++;
    checks++; if (state !== READ_DATA) $display("FAIL rd_data waiting state: got %0d want 4", state); else passes++;
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      bits[7-k] = MISO;
      checks++; if (rd_addr_flag !== 1'b1) $display("FAIL rd_data flag during shift %0d: got %b want 1", k, rd_addr_flag); else passes++;
      step();
    end
    checks++; if (bits !== 8'hA5) $display("FAIL rd_data MISO bits: got %h want a5", bits); else passes++;
    checks++; if (MISO !== 1'b0) $display("FAIL rd_data MISO after: got %b want 0", MISO); else passes++;
    checks++; if (rd_addr_flag !== 1'b0) $display("FAIL rd_data flag cleared: got %b want 0", rd_addr_flag); else passes++;
    tx_data = 8'hFF; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    checks++; if (MISO !== 1'b0) $display("FAIL rd_data second tx_valid MISO: got %b want 0", MISO); else passes++;
    end_frame();
  endtask

  task automatic test_abort();
    logic [9:0] vpat, cap;
    start_frame(1'b1);
    send_word(10'h2FF, 5, vpat, cap);
    checks++; if (vpat !== 10'b0) $display("FAIL abort partial strobe: got %b want 0", vpat); else passes++;
    end_frame();
    checks++; if (state !== IDLE) $display("FAIL abort state: got %0d want 0", state); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL abort rx_valid: got %b want 0", rx_valid); else passes++;
    checks++; if (rx_data !== 10'h000) $display("FAIL abort rx_data: got %h want 000", rx_data); else passes++;
    checks++; if (rd_addr_flag !== 1'b0) $display("FAIL abort flag: got %b want 0", rd_addr_flag); else passes++;
    start_frame(1'b0);
    send_word(10'h0F0, 10, vpat, cap);
    checks++; if (vpat !== 10'b00_0000_0001) $display("FAIL abort_next rx_valid timing: got %b want 0000000001", vpat); else passes++;
    checks++; if (cap !== 10'h0F0) $display("FAIL abort_next rx_data: got %h want 0f0", cap); else passes++;
    end_frame();
  endtask

  task automatic test_async_reset();
    logic [9:0] vpat, cap;
    start_frame(1'b1);
    send_word(10'h2A0, 10, vpat, cap);
    end_frame();
    start_frame(1'b1);
    send_word(10'h3C3, 10, vpat, cap);
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    checks++; if (MISO !== 1'b1) $display("FAIL areset pre MISO: got %b want 1", MISO); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (MISO !== 1'b0) $display("FAIL areset MISO: got %b want 0", MISO); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL areset rx_valid: got %b want 0", rx_valid); else passes++;
    checks++; if (rx_data !== 10'h000) $display("FAIL areset rx_data: got %h want 000", rx_data); else passes++;
    checks++; if (rd_addr_flag !== 1'b0) $display("FAIL areset flag: got %b want 0", rd_addr_flag); else passes++;
    checks++; if (state !== IDLE) $display("FAIL areset state: got %0d want 0", state); else passes++;
    SS_n = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

`ifdef SPI_READ_TIMEOUT_EN
  task automatic test_timeout();
    logic [9:0] vpat, cap;
    logic [5:0] tpat;
    logic [5:0] mpat;
    start_frame(1'b1);
    send_word(10'h2AA, 10, vpat, cap);
    end_frame();
    start_frame(1'b1);
    send_word(10'h300, 10, vpat, cap);
    tpat = '0;
    mpat = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      tpat[c] = rd_timeout;
      mpat[c] = MISO;
    end
    checks++; if (tpat !== 6'b001000) $display("FAIL timeout pulse: got %b want 001000", tpat); else passes++;
    checks++; if (mpat !== 6'b000000) $display("FAIL timeout MISO: got %b want 000000", mpat); else passes++;
    checks++; if (rd_addr_flag !== 1'b0) $display("FAIL timeout flag: got %b want 0", rd_addr_flag); else passes++;
    tx_data = 8'hFF; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    checks++; if (MISO !== 1'b0) $display("FAIL timeout late tx_valid MISO: got %b want 0", MISO); else passes++;
    end_frame();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_pair();
    test_abort();
    test_async_reset();
`ifdef SPI_READ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Serial front-end and sequencer for the 256x8 SPI RAM.
- Deserialises MOSI frames into 10-bit command words and pulses rx_valid toward the RAM.
- Captures the RAM's tx_data/tx_valid response and serialises it on MISO.
- Tracks read-address/read-data ordering so the RAM always sees a legal command sequence.

Parameters:
- ADDR_SIZE, 8, RAM address/data byte width; payload is ADDR_SIZE+2 bits.
- TIMEOUT_CYCLES, 4, cycles to wait for tx_valid in READ_DATA (used only with the optional feature).

Ports:
- clk  input  1  system clock; SPI bit clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active-low; frames one transaction.
- MOSI  input  1  serial data in, MSB first, sampled on posedge clk.
- MISO  output  1  serial data out, MSB first.
- rx_data  output  ADDR_SIZE+2  command word to RAM: [9:8] command, [7:0] address/data.
- rx_valid  output  1  one-cycle strobe; rx_data is valid while it is high.
- tx_data  input  ADDR_SIZE  read byte from RAM.
- tx_valid  input  1  RAM read-data strobe.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rx_data=0, rx_valid=0, MISO=0, bit counter=0, rd_addr_flag=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE -> CHK_CMD on a cycle with SS_n=0.
- CHK_CMD samples the selector bit on MOSI:
  - 0 -> WRITE.
  - 1 and rd_addr_flag=0 -> READ_ADD.
  - 1 and rd_addr_flag=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift 10 MOSI bits MSB first into rx_data. On the cycle the 10th bit is captured, rx_valid=1 for exactly one cycle (registered; visible the following cycle).
- Payload [9:8] is forwarded unchanged; the controller does not check it against the selector bit.
- READ_ADD: rd_addr_flag set when rx_valid fires.
- READ_DATA read-back sequence:
  - After rx_valid, wait for tx_valid.
  - On tx_valid, latch tx_data into the output shift register.
  - Drive MISO with bit 7 on the next cycle, then bits 6..0 on successive cycles (8 cycles total).
  - rd_addr_flag cleared when the 8th bit has been driven.
  - MISO=0 at all other times.
- After a frame completes, remain in the current state with no further strobes until SS_n=1, then go to IDLE.
- SS_n=1 in any state: next cycle IDLE; bit counter and shift registers cleared; no rx_valid issued. rd_addr_flag is kept unless the read-back completed.
- Extra MOSI bits beyond 10 within a frame are ignored.
- tx_valid outside READ_DATA is ignored.
- Latency: selector bit at cycle 0 → rx_valid at cycle 11 → MISO bit 7 at tx_valid+1.

Optional Feature:
- Macro: SPI_READ_TIMEOUT_EN.
- Defined:
  - In READ_DATA, after rx_valid, a counter waits up to TIMEOUT_CYCLES for tx_valid.
  - On expiry: go to IDLE-wait (ignore MOSI until SS_n=1), clear rd_addr_flag, drive MISO=0 for the rest of the frame.
  - Adds output rd_timeout (1 bit), pulsed high for 1 cycle on expiry; reset value 0.
- Not defined: READ_DATA waits for tx_valid indefinitely while SS_n=0; no rd_timeout port.

Decomposition:
- Shared package spi_pkg:
  - state enum {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA}.
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - WORD_W=ADDR_SIZE+2.
- One sub-module, spi_shift_reg:
  - parameterised-width shift register with bit counter and done flag.
  - instanced once for serial-in (10 bits) and once for serial-out (8 bits).

Test Plan:
- Write address: SS_n=0, MOSI 0 then 00_0000_0101 → rx_data=10'h005, one rx_valid pulse at cycle 11; SS_n=1 → IDLE.
- Write data: selector 0 then 01_1010_1010 → rx_data=10'h1AA, single rx_valid.
- Read pair:
  - Frame 1: selector 1 then 10_0000_0101 → rx_data=10'h205, rd_addr_flag=1.
  - Frame 2: selector 1 then 11_xxxx_xxxx → rx_data[9:8]=11; stimulate tx_valid with tx_data=8'hA5 → MISO 1,0,1,0,0,1,0,1 on the next 8 cycles; rd_addr_flag=0.
- Abort: SS_n=1 after 5 payload bits → no rx_valid, state=IDLE next cycle. A following full write frame decodes correctly.
- Async reset: assert rst_n=0 mid-READ_DATA shift → MISO, rx_valid, rx_data and rd_addr_flag are 0 immediately, independent of clk.
- With SPI_READ_TIMEOUT_EN, TIMEOUT_CYCLES=4: no tx_valid after a read-data frame → rd_timeout pulses 4 cycles after rx_valid, MISO stays 0, rd_addr_flag=0.
